// File: rtl/sine_addr_gen.sv
// Phase-accumulator address generator for a dual-port sine ROM: two registered
// read addresses (port 2 phase-offset), ROM enables and a latency-aligned data_valid.
module sine_addr_gen #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [ACC_W-1:0]  incr,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              en1,
  output logic              en2,
  output logic              data_valid,
  output logic              busy,
  output logic              wrap,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Control is pulse based, no handshake: start is taken only in IDLE with stop low;
  // stop is taken in RUN; both are ignored in DRAIN.
  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  incr_q;
  logic [ADDR_W-1:0] offset_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_q;
  logic              en;

  logic [ACC_W:0]    acc_sum;
  logic [ADDR_W-1:0] acc_top;
  logic              run_done;
  logic              cnt_max;

  assign acc_sum  = {1'b0, acc} + {1'b0, incr_q};
  assign acc_top  = acc[ACC_W-1 -: ADDR_W];
  assign run_done = stop || ((len_q != '0) && (cnt == len_q));
  assign cnt_max  = &cnt;

  assign en1       = en;
  assign en2       = en;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      incr_q     <= '0;
      offset_q   <= '0;
      cnt        <= '0;
      len_q      <= '0;
      en         <= 1'b0;
      addr1      <= '0;
      addr2      <= '0;
      data_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      wrap       <= 1'b0;
      data_valid <= en;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state    <= S_RUN;
            incr_q   <= incr;
            offset_q <= offset;
            len_q    <= burst_len;
            addr1    <= '0;
            addr2    <= offset;
            acc      <= incr;
            cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
            en       <= 1'b1;
          end
        end
        S_RUN: begin
          if (run_done) begin
            state <= S_DRAIN;
            en    <= 1'b0;
          end else begin
            addr1 <= acc_top;
            addr2 <= acc_top + offset_q;
            acc   <= acc_sum[ACC_W-1:0];
            if (!cnt_max) cnt <= cnt + 1'b1;
            // Retune only at a period boundary so the waveform never glitches.
            if (acc_sum[ACC_W]) begin
              wrap     <= 1'b1;
              incr_q   <= incr;
              offset_q <= offset;
            end
          end
        end
        S_DRAIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
